// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register offsets, STATUS/CTRL bit positions, frame shape and FSM encoding.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int unsigned STATUS_FULL    = 0;
    localparam int unsigned STATUS_EMPTY   = 1;
    localparam int unsigned STATUS_BUSY    = 2;
    localparam int unsigned STATUS_IRQ     = 3;
    localparam int unsigned STATUS_OVR     = 4;
    localparam int unsigned STATUS_CNT_LSB = 5;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_OVR_CLR = 1;
    localparam int unsigned CTRL_IRQ_CLR = 2;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    // STATUS only has three bits for the fill level.
    function automatic logic [2:0] sat_count3(input int unsigned cnt);
        return (cnt > 7) ? 3'd7 : 3'(cnt);
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by one responder: strobes, address, write data
// and the combinational read-data return.
interface mmio_uart_tx_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the transmit path. A push while full is accepted only
// when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [Width-1:0]             din_i,
    output logic [Width-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);
    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AddrW'(1);
        if (do_pop)  rptr_d = rptr_q + AddrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TXDATA/STATUS/CTRL/DIV
// registers, a transmit FIFO and the baud-divided serializer.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0030,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DEF_DIV    = 16'd5208
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          UART_TX,
    output logic          irqout
);
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0]  LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LastStop = 3'(STOP_BITS - 1);

    logic            sel;
    logic [1:0]      reg_idx;
    logic            wr_txdata, wr_ctrl, wr_div;
    logic            push, pop, full, empty, drained, bit_done;
    logic [7:0]      fifo_dout;
    logic [CntW-1:0] fifo_count;
    logic [31:0]     status;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, div_lat_q, div_lat_d, div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_en_q, irq_en_d, overrun_q, overrun_d;
    logic        irq_pend_q, irq_pend_d, irqout_q, irqout_d;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

    assign sel       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = bus.addr[3:2];
    assign wr_txdata = bus.wr & sel & (reg_idx == REG_TXDATA);
    assign wr_ctrl   = bus.wr & sel & (reg_idx == REG_CTRL);
    assign wr_div    = bus.wr & sel & (reg_idx == REG_DIV);
    assign push      = wr_txdata;

    uart_tx_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.wdata[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign bit_done = (cnt_q == div_lat_q - 16'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        div_lat_d = div_lat_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        drained   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_dout;
                    div_lat_d = div_q;
                    tx_d      = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q != LastStop) begin
                        bit_d = bit_q + 3'd1;
                    end else if (!empty) begin
                        // Chain straight into the next frame without an idle bit.
                        pop       = 1'b1;
                        shift_d   = fifo_dout;
                        div_lat_d = div_q;
                        tx_d      = 1'b0;
                        state_d   = StStart;
                    end else begin
                        drained = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d      = div_q;
        irq_en_d   = irq_en_q;
        overrun_d  = overrun_q;
        irq_pend_d = irq_pend_q;
        if (wr_div) div_d = (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
        if (wr_ctrl) begin
            irq_en_d = bus.wdata[CTRL_IRQ_EN];
            if (bus.wdata[CTRL_OVR_CLR]) overrun_d = 1'b0;
            if (bus.wdata[CTRL_IRQ_CLR]) irq_pend_d = 1'b0;
        end
        // Sets come last so they win over a same-cycle clear.
        if (push && full && !pop) overrun_d = 1'b1;
        if (drained) irq_pend_d = 1'b1;
        irqout_d = irq_pend_q & irq_en_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            div_lat_q  <= DEF_DIV;
            tx_q       <= 1'b1;
            div_q      <= DEF_DIV;
            irq_en_q   <= 1'b0;
            overrun_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            irqout_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            div_lat_q  <= div_lat_d;
            tx_q       <= tx_d;
            div_q      <= div_d;
            irq_en_q   <= irq_en_d;
            overrun_q  <= overrun_d;
            irq_pend_q <= irq_pend_d;
            irqout_q   <= irqout_d;
        end
    end

    always_comb begin
        status                           = '0;
        status[STATUS_FULL]              = full;
        status[STATUS_EMPTY]             = empty;
        status[STATUS_BUSY]              = (state_q != StIdle);
        status[STATUS_IRQ]               = irq_pend_q;
        status[STATUS_OVR]               = overrun_q;
        status[STATUS_CNT_LSB +: 3]      = sat_count3(32'(fifo_count));
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && sel) begin
            case (reg_idx)
                REG_STATUS: bus.rdata = status;
                REG_CTRL:   bus.rdata = {31'd0, irq_en_q};
                REG_DIV:    bus.rdata = {16'd0, div_q};
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign UART_TX = tx_q;
    assign irqout  = irqout_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register table, directed frame sequences and random
// rounds, with the serial line checked against waveforms built from byte lists.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h4000_0030;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_ST   = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
    localparam logic [31:0] A_DIV  = BASE + 32'd12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic UART_TX;
    logic irqout;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DEF_DIV    (16'd5208)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .UART_TX (UART_TX),
        .irqout  (irqout)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   cap_en = 1'b0;
    logic line_q[$];
    logic irq_q[$];
    logic exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cap_en) begin
            line_q.push_back(UART_TX);
            irq_q.push_back(irqout);
        end
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.wr    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(posedge clk);
        #1;
        bus_if.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.rd   = 1'b1;
        bus_if.addr = a;
        #1;
        d         = bus_if.rdata;
        bus_if.rd = 1'b0;
    endtask

    task automatic start_capture();
        line_q.delete();
        irq_q.delete();
        exp_q.delete();
        cap_en = 1'b1;
    endtask

    task automatic add_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endtask

    // 8N1: start low, data LSB first, stop high, each bit d samples wide.
    task automatic add_frame(input logic [7:0] b, input int d);
        repeat (d) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (d) exp_q.push_back(b[i]);
        repeat (d) exp_q.push_back(1'b1);
    endtask

    task automatic compare_line(input string name);
        int guard = 0;
        int mism = 0;
        int first = -1;
        while (line_q.size() < exp_q.size() && guard < exp_q.size() + 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        cap_en = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= line_q.size() || line_q[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        check(name, mism, 0);
        if (mism != 0) $display("  %s: first differing sample %0d of %0d", name, first, exp_q.size());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  rb [4];
        int          c0, k, d, de, n;

        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        bus_if.addr = A_ST;
        #1;
        check("rdata_without_rd", bus_if.rdata, 32'h0);

        vecs.push_back('{1'b0, A_ST,           32'h0,         32'h0000_0002});
        vecs.push_back('{1'b0, A_DIV,          32'h0,         32'd5208});
        vecs.push_back('{1'b0, A_CTRL,         32'h0,         32'h0});
        vecs.push_back('{1'b0, A_TX,           32'h0,         32'h0});
        vecs.push_back('{1'b0, BASE + 32'd7,   32'h0,         32'h0000_0002});
        vecs.push_back('{1'b1, A_DIV,          32'h0,         32'h0});
        vecs.push_back('{1'b0, A_DIV,          32'h0,         32'h1});
        vecs.push_back('{1'b1, A_DIV,          32'h0001_2345, 32'h0});
        vecs.push_back('{1'b0, A_DIV,          32'h0,         32'h2345});
        vecs.push_back('{1'b1, A_CTRL,         32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, A_CTRL,         32'h0,         32'h1});
        vecs.push_back('{1'b0, A_ST,           32'h0,         32'h0000_0002});
        vecs.push_back('{1'b1, A_CTRL,         32'h0,         32'h0});
        vecs.push_back('{1'b0, A_CTRL,         32'h0,         32'h0});
        vecs.push_back('{1'b0, BASE + 32'd16,  32'h0,         32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010,  32'h0,         32'h0});
        vecs.push_back('{1'b0, 32'h4000_0020,  32'h0,         32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, r);
                check($sformatf("vec%0d_rd_%08h", i, vecs[i].addr), r, vecs[i].exp);
            end
        end

        // Single byte with interrupt enabled.
        bus_write(A_DIV, 32'd4);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_TX, 32'hA5);
        start_capture();
        add_idle(1);
        add_frame(8'hA5, 4);
        add_idle(4);
        compare_line("single_a5_line");
        check("irqout_at_stop_end", irq_q[41], 1'b0);
        check("irqout_one_later", irq_q[42], 1'b1);
        bus_read(A_ST, r);
        check("single_status", r, 32'h0000_000A);

        // Reset in the middle of a start bit.
        bus_write(A_TX, 32'hFF);
        repeat (2) @(negedge clk);
        #1;
        check("pre_reset_tx", UART_TX, 1'b0);
        check("pre_reset_irq", irqout, 1'b1);
        reset = 1'b0;
        #1;
        check("reset_tx_high", UART_TX, 1'b1);
        check("reset_irq_low", irqout, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus_read(A_ST, r);
        check("post_reset_status", r, 32'h0000_0002);
        bus_read(A_DIV, r);
        check("post_reset_div", r, 32'd5208);
        bus_read(A_CTRL, r);
        check("post_reset_ctrl", r, 32'h0);

        // Back-to-back frames, busy must hold until the last stop bit ends.
        bus_write(A_DIV, 32'd2);
        bus_write(A_TX, 32'h01);
        start_capture();
        c0 = cyc;
        bus_write(A_TX, 32'h02);
        bus_write(A_TX, 32'h03);
        bus_write(A_TX, 32'h04);
        k = -1;
        for (int i = 0; i < 300; i++) begin
            bus_read(A_ST, r);
            if (!r[2]) begin
                k = cyc - c0;
                break;
            end
        end
        check("busy_drop_cycle", k, 81);
        add_idle(1);
        for (int i = 1; i <= 4; i++) add_frame(8'(i), 2);
        add_idle(3);
        compare_line("b2b_line");
        bus_read(A_ST, r);
        check("b2b_status", r, 32'h0000_000A);
        bus_write(A_CTRL, 32'h4);

        // Overrun: one byte in flight, four held, sixth dropped.
        bus_write(A_DIV, 32'd100);
        bus_write(A_TX, 32'h11);
        start_capture();
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        bus_write(A_TX, 32'h44);
        bus_write(A_TX, 32'h55);
        bus_write(A_TX, 32'h66);
        bus_read(A_ST, r);
        check("overrun_status", r, 32'h0000_0095);
        bus_write(A_CTRL, 32'h2);
        bus_read(A_ST, r);
        check("overrun_cleared", r, 32'h0000_0085);
        add_idle(1);
        add_frame(8'h11, 100);
        add_frame(8'h22, 100);
        add_frame(8'h33, 100);
        add_frame(8'h44, 100);
        add_frame(8'h55, 100);
        add_idle(5);
        compare_line("overrun_line");
        bus_write(A_CTRL, 32'h4);

        // Writes outside the window must not reach the FIFO.
        bus_write(BASE + 32'd16, 32'h77);
        bus_write(32'h0000_0030, 32'h77);
        bus_read(A_ST, r);
        check("decode_status", r, 32'h0000_0002);

        // Divisor 0 becomes 1; a mid-frame DIV write only affects later frames.
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, r);
        check("div0_reads_1", r, 32'd1);
        bus_write(A_TX, 32'h96);
        start_capture();
        add_idle(1);
        add_frame(8'h96, 1);
        add_idle(3);
        compare_line("div1_line");
        bus_write(A_DIV, 32'd3);
        bus_write(A_TX, 32'h3C);
        start_capture();
        bus_write(A_TX, 32'hC3);
        bus_write(A_DIV, 32'd6);
        add_idle(1);
        add_frame(8'h3C, 3);
        add_frame(8'hC3, 6);
        add_idle(3);
        compare_line("div_change_line");
        bus_read(A_DIV, r);
        check("div_change_readback", r, 32'd6);
        bus_write(A_CTRL, 32'h4);

        // Random divisors and byte bursts.
        for (int rnd = 0; rnd < 6; rnd++) begin
            d  = $urandom_range(0, 4);
            de = (d == 0) ? 1 : d;
            n  = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) rb[j] = 8'($urandom);
            bus_write(A_DIV, 32'(d));
            bus_read(A_DIV, r);
            check($sformatf("rnd%0d_div", rnd), r, 32'(de));
            bus_write(A_TX, {24'd0, rb[0]});
            start_capture();
            for (int j = 1; j < n; j++) bus_write(A_TX, {24'd0, rb[j]});
            add_idle(1);
            for (int j = 0; j < n; j++) add_frame(rb[j], de);
            add_idle(3);
            compare_line($sformatf("rnd%0d_line", rnd));
            bus_read(A_ST, r);
            check($sformatf("rnd%0d_status", rnd), r, 32'h0000_000A);
            bus_write(A_CTRL, 32'h4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
